pc_fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle/pipelined CPU core. Holds the program counter and drives the byte address of the combinational instruction memory (big-endian, 4 bytes per instruction). Latches each returned word into an instruction register (IR) for the decode stage. Applies branch/jump redirects requested by decode, stops on HALT (opcode 111111), and traps out-of-range fetches.

---
 rtl/pc_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction fetch stage. Holds the program counter, presents it to a
// combinational instruction memory, and latches each returned word into the
// instruction register for decode. Applies branch/jump redirects requested by
// decode, stops on HALT (opcode 6'b111111), and traps out-of-range fetches.
//
// Parameters:
//   RESET_PC    PC loaded on reset (word-aligned)
//   IMEM_BYTES  instruction memory size in bytes
//
// Ports:
//   CLK          in   1   clock, rising edge
//   Reset        in   1   synchronous active-high reset
//   IDataOut     in  32   instruction word at IAddr (combinational memory)
//   Stall        in   1   decode back-pressure
//   BranchTaken  in   1   IR holds a taken conditional branch
//   JumpTaken    in   1   IR holds a jump
//   IAddr        out 32   current PC
//   InstrOut     out 32   instruction register
//   IRPC         out 32   address the IR word was fetched from
//   IRValid      out  1   IR holds a live instruction
//   Halted       out  1   HALT reached, fetch stopped
//   Fault        out  1   illegal fetch address, fetch stopped
//   FetchCount   out 16   instructions accepted into IR (wraps)
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_BYTES = 128
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] IDataOut,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic        JumpTaken,
  output logic [31:0] IAddr,
  output logic [31:0] InstrOut,
  output logic [31:0] IRPC,
  output logic        IRValid,
  output logic        Halted,
  output logic        Fault,
  output logic [15:0] FetchCount
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [5:0] OPC_HALT = 6'b111111;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] ir_r, ir_s;
  logic [31:0] ir_pc_r, ir_pc_s;
  logic        ir_valid_r, ir_valid_s;
  logic        halted_r, halted_s;
  logic        fault_r, fault_s;
  logic [15:0] fetch_count_r, fetch_count_s;
  logic        redirect_s;

  // A fetch is legal when word-aligned and all four bytes lie inside memory.
  // Computed in 33 bits so addresses near 2^32 cannot wrap into range.
  function automatic logic addr_legal(input logic [31:0] addr);
    logic [32:0] last_byte;
    last_byte  = {1'b0, addr} + 33'd3;
    addr_legal = (addr[1:0] == 2'b00) && (last_byte <= (33'(IMEM_BYTES) - 33'd1));
  endfunction

  // PC-relative branch target: IRPC + 4 + sext(imm16) * 4, modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] ir_pc,
                                                input logic [31:0] ir);
    logic [31:0] offset;
    offset        = {{14{ir[15]}}, ir[15:0], 2'b00};
    branch_target = ir_pc + 32'd4 + offset;
  endfunction

  // Pseudo-direct jump target: top nibble of IRPC+4 with the 26-bit index.
  function automatic logic [31:0] jump_target(input logic [31:0] ir_pc,
                                              input logic [31:0] ir);
    logic [31:0] seq_pc;
    seq_pc      = ir_pc + 32'd4;
    jump_target = {seq_pc[31:28], ir[25:0], 2'b00};
  endfunction

  // Redirects only count when decode is looking at a live instruction.
  always_comb begin
    redirect_s = ir_valid_r && (BranchTaken || JumpTaken);
  end

  // Next-state and next-register logic for the fetch FSM.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    ir_s          = ir_r;
    ir_pc_s       = ir_pc_r;
    ir_valid_s    = ir_valid_r;
    halted_s      = halted_r;
    fault_s       = fault_r;
    fetch_count_s = fetch_count_r;

    case (state_r)
      ST_RUN: begin
        if (redirect_s) begin
          // Redirect beats stall, fault and HALT: the word now on IDataOut
          // is on the wrong path and gets squashed.
          if (BranchTaken) begin
            pc_s = branch_target(ir_pc_r, ir_r);
          end else begin
            pc_s = jump_target(ir_pc_r, ir_r);
          end
          ir_valid_s = 1'b0;
        end else if (!addr_legal(pc_r)) begin
          state_s    = ST_FAULT;
          fault_s    = 1'b1;
          ir_valid_s = 1'b0;
        end else if (Stall) begin
          pc_s = pc_r;
        end else begin
          ir_s          = IDataOut;
          ir_pc_s       = pc_r;
          ir_valid_s    = 1'b1;
          fetch_count_s = fetch_count_r + 16'd1;
          if (IDataOut[31:26] == OPC_HALT) begin
            state_s  = ST_HALTED;
            halted_s = 1'b1;
          end else begin
            pc_s = pc_r + 32'd4;
          end
        end
      end

      ST_HALTED: begin
        // Keep the HALT word visible while decode stalls so it is consumed
        // exactly once; once dropped it never comes back.
        ir_valid_s = ir_valid_r & Stall;
      end

      ST_FAULT: begin
        ir_valid_s = 1'b0;
      end

      default: begin
        // Unreachable encoding: park in FAULT so software sees a stop.
        state_s    = ST_FAULT;
        fault_s    = 1'b1;
        ir_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      ir_r          <= 32'd0;
      ir_pc_r       <= 32'd0;
      ir_valid_r    <= 1'b0;
      halted_r      <= 1'b0;
      fault_r       <= 1'b0;
      fetch_count_r <= 16'd0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      ir_r          <= ir_s;
      ir_pc_r       <= ir_pc_s;
      ir_valid_r    <= ir_valid_s;
      halted_r      <= halted_s;
      fault_r       <= fault_s;
      fetch_count_r <= fetch_count_s;
    end
  end

  assign IAddr      = pc_r;
  assign InstrOut   = ir_r;
  assign IRPC       = ir_pc_r;
  assign IRValid    = ir_valid_r;
  assign Halted     = halted_r;
  assign Fault      = fault_r;
  assign FetchCount = fetch_count_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit. A small program image sits in a
// combinational memory model; the bench plays the decode stage. Expected
// fetched (address, word) pairs are queued as stimulus is driven and popped
// when the DUT presents a new valid instruction.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] IDataOut;
  logic        Stall;
  logic        BranchTaken;
  logic        JumpTaken;
  logic [31:0] IAddr;
  logic [31:0] InstrOut;
  logic [31:0] IRPC;
  logic        IRValid;
  logic        Halted;
  logic        Fault;
  logic [15:0] FetchCount;

  logic [31:0] mem [0:31];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pc_fetch_unit #(.RESET_PC(32'd0), .IMEM_BYTES(128)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .IDataOut   (IDataOut),
    .Stall      (Stall),
    .BranchTaken(BranchTaken),
    .JumpTaken  (JumpTaken),
    .IAddr      (IAddr),
    .InstrOut   (InstrOut),
    .IRPC       (IRPC),
    .IRValid    (IRValid),
    .Halted     (Halted),
    .Fault      (Fault),
    .FetchCount (FetchCount)
  );

  always #5 CLK = ~CLK;

  // Out-of-range reads return a HALT word so a fault must win over halting.
  assign IDataOut = (IAddr < 32'd128) ? mem[IAddr[6:2]] : 32'hFC00_0000;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.word = mem[a[6:2]];
    sb.push_back(e);
  endtask

  // One clock with the given decode inputs; checks IRValid and, when a new
  // instruction is expected, pops the scoreboard.
  task automatic step(input logic s, input logic b, input logic j,
                      input logic exp_new, input logic exp_valid);
    exp_t e;
    Stall       = s;
    BranchTaken = b;
    JumpTaken   = j;
    @(posedge CLK);
    #1;
    check_val("irvalid", {31'd0, IRValid}, {31'd0, exp_valid});
    if (exp_new) begin
      check_val("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("irpc", IRPC, e.pc);
        check_val("instr", InstrOut, e.word);
      end
    end
    Stall       = 1'b0;
    BranchTaken = 1'b0;
    JumpTaken   = 1'b0;
  endtask

  task automatic do_reset(input int n, input logic s);
    Reset = 1'b1;
    Stall = s;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
    end
    #1;
    Reset = 1'b0;
    Stall = 1'b0;
    sb.delete();
  endtask

  task automatic check_reset_state();
    check_val("rst_iaddr", IAddr, 32'd0);
    check_val("rst_instr", InstrOut, 32'd0);
    check_val("rst_irpc", IRPC, 32'd0);
    check_val("rst_irvalid", {31'd0, IRValid}, 32'd0);
    check_val("rst_halted", {31'd0, Halted}, 32'd0);
    check_val("rst_fault", {31'd0, Fault}, 32'd0);
    check_val("rst_count", {16'd0, FetchCount}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] r;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'd0;
    end
    mem[0]  = 32'h2001_0001;
    mem[1]  = 32'h2002_0002;
    mem[2]  = 32'h2003_0003;
    mem[3]  = 32'h1000_0002;  // 12: branch -> 24
    mem[4]  = 32'h0800_0002;  // 16: branch -> 28, jump -> 8
    mem[5]  = 32'h2006_0006;
    mem[6]  = 32'h1000_0004;  // 24: branch -> 44, jump -> 16
    mem[7]  = 32'h0800_0009;  // 28: jump -> 36
    mem[8]  = 32'h0800_0017;  // 32: branch -> 0x80
    mem[9]  = 32'h200A_000A;
    mem[10] = 32'h1000_FFFB;  // 40: branch -> 24
    mem[11] = 32'hFC00_0000;  // 44: HALT
    Stall       = 1'b0;
    BranchTaken = 1'b0;
    JumpTaken   = 1'b0;
    Reset       = 1'b1;

    // Sequential fetch, branches, wrong-path HALT squash, HALT.
    do_reset(2, 1'b0);
    check_reset_state();
    for (int a = 0; a <= 40; a += 4) begin
      push_fetch(32'(a));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (a == 20) check_val("count6", {16'd0, FetchCount}, 32'd6);
    end
    check_val("iaddr_at_halt_word", IAddr, 32'd44);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("bwd_target", IAddr, 32'd24);
    check_val("no_wrong_path_halt", {31'd0, Halted}, 32'd0);
    check_val("count_squash", {16'd0, FetchCount}, 32'd11);
    push_fetch(32'd24);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("fwd_target", IAddr, 32'd44);
    push_fetch(32'd44);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("halted_set", {31'd0, Halted}, 32'd1);
    check_val("count_halt", {16'd0, FetchCount}, 32'd13);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      r = 3'($urandom());
      step(r[0], r[1], r[2], 1'b0, 1'b0);
      check_val("halt_iaddr", IAddr, 32'd44);
      check_val("halt_count", {16'd0, FetchCount}, 32'd13);
      check_val("halt_flag", {31'd0, Halted}, 32'd1);
      check_val("halt_irpc", IRPC, 32'd44);
    end
    do_reset(1, 1'b0);
    check_reset_state();

    // Stall, stall+redirect, jump, branch-over-jump, ignored redirect.
    push_fetch(32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    push_fetch(32'd4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    push_fetch(32'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("stall_irpc", IRPC, 32'd8);
      check_val("stall_instr", InstrOut, 32'h2003_0003);
      check_val("stall_iaddr", IAddr, 32'd12);
    end
    push_fetch(32'd12);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_val("count_after_stall", {16'd0, FetchCount}, 32'd4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("stall_redirect", IAddr, 32'd24);
    check_val("count_stall_redir", {16'd0, FetchCount}, 32'd4);
    push_fetch(32'd24);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("jump_target", IAddr, 32'd16);
    push_fetch(32'd16);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("branch_wins", IAddr, 32'd28);
    push_fetch(32'd28);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("jump_target2", IAddr, 32'd36);
    push_fetch(32'd36);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_val("ignored_redirect", IAddr, 32'd40);
    check_val("count_phase2", {16'd0, FetchCount}, 32'd8);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset(1, 1'b1);
    check_reset_state();

    // Branch out of range -> fault, then reset.
    for (int a = 0; a <= 32; a += 4) begin
      push_fetch(32'(a));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("oob_target", IAddr, 32'h0000_0080);
    check_val("fault_not_yet", {31'd0, Fault}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("fault_set", {31'd0, Fault}, 32'd1);
    check_val("fault_not_halt", {31'd0, Halted}, 32'd0);
    check_val("fault_count", {16'd0, FetchCount}, 32'd9);
    for (int i = 0; i < 5; i++) begin
      r = 3'($urandom());
      step(r[0], r[1], r[2], 1'b0, 1'b0);
      check_val("fault_hold", {31'd0, Fault}, 32'd1);
      check_val("fault_iaddr", IAddr, 32'h0000_0080);
    end
    do_reset(1, 1'b0);
    check_reset_state();
    push_fetch(32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
